// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit for the E stage of the five-stage MIPS pipeline.
//
// Holds the architectural HI/LO registers and runs multi-cycle mult/multu
// (and div/divu when MDU_DIV_EN is defined). The arithmetic is done in the
// start cycle and parked in tHI/tLO. A down-counter then models the latency.
// HI/LO are committed on the edge where the counter expires.
//
// Build option:
//   MDU_DIV_EN  defined   -> div/divu implemented (DIV state + divider)
//               undefined -> ops 3/4 behave as "none"
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   reset        in   asynchronous active-high reset
//   E_O1         in   [31:0] rs operand
//   E_O2         in   [31:0] rt operand
//   E_MDUOp      in   [3:0]  0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,
//                            6 mflo,7 mthi,8 mtlo, 9-15 none
//   E_MDU_Start  out  mult/div op presented while not busy
//   E_MDU_Busy   out  operation in flight (registered)
//   E_MDU_O      out  [31:0] HI for mfhi, LO for mflo, else 0
//   HI, LO       out  [31:0] architectural registers
//   state_dbg    out  [1:0]  current FSM state (0 IDLE, 1 MULT, 2 DIV)
//
// Handshake: E_MDU_Start acts as "valid & ready". The op is accepted on the
// rising edge where E_MDU_Start is 1. Any op seen while E_MDU_Busy is 1 is
// dropped without side effects. The hazard unit stalls on Start|Busy.

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_O1,
  input  logic [31:0] E_O2,
  input  logic [3:0]  E_MDUOp,
  output logic        E_MDU_Start,
  output logic        E_MDU_Busy,
  output logic [31:0] E_MDU_O,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] thi, thi_d, tlo, tlo_d;
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod;
  logic        is_mult, is_div;

  assign is_mult = (E_MDUOp == 4'd1) || (E_MDUOp == 4'd2);
`ifdef MDU_DIV_EN
  assign is_div  = (E_MDUOp == 4'd3) || (E_MDUOp == 4'd4);
`else
  assign is_div  = 1'b0;
`endif

  assign E_MDU_Busy  = (state != S_IDLE);
  assign E_MDU_Start = (is_mult || is_div) && !E_MDU_Busy;
  assign state_dbg   = state;

  always_comb begin
    E_MDU_O = 32'd0;
    if (E_MDUOp == 4'd5)      E_MDU_O = HI;
    else if (E_MDUOp == 4'd6) E_MDU_O = LO;
  end

  // Product: sign-extend both operands to 64 bits for mult, zero-extend for multu.
  always_comb begin
    if (E_MDUOp == 4'd1)
      prod = $signed({{32{E_O1[31]}}, E_O1}) * $signed({{32{E_O2[31]}}, E_O2});
    else
      prod = {32'd0, E_O1} * {32'd0, E_O2};
  end

`ifdef MDU_DIV_EN
  logic [31:0] quo, rem;

  // Divide by zero parks the current HI/LO in tHI/tLO. HI/LO cannot change
  // while busy, so committing them at completion leaves HI/LO untouched.
  // The one signed overflow case is pinned explicitly rather than relying
  // on the operator's behaviour.
  always_comb begin
    quo = 32'd0;
    rem = 32'd0;
    if (E_O2 == 32'd0) begin
      quo = LO;
      rem = HI;
    end else if (E_MDUOp == 4'd3) begin
      if (E_O1 == 32'h8000_0000 && E_O2 == 32'hFFFF_FFFF) begin
        quo = 32'h8000_0000;
        rem = 32'd0;
      end else begin
        quo = $signed(E_O1) / $signed(E_O2);
        rem = $signed(E_O1) % $signed(E_O2);
      end
    end else begin
      quo = E_O1 / E_O2;
      rem = E_O1 % E_O2;
    end
  end
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    thi_d   = thi;
    tlo_d   = tlo;
    hi_d    = HI;
    lo_d    = LO;
    case (state)
      S_IDLE: begin
        if (is_mult) begin
          thi_d   = prod[63:32];
          tlo_d   = prod[31:0];
          cnt_d   = MULT_N;
          state_d = S_MULT;
        end
`ifdef MDU_DIV_EN
        else if (is_div) begin
          thi_d   = rem;
          tlo_d   = quo;
          cnt_d   = DIV_N;
          state_d = S_DIV;
        end
`endif
        else if (E_MDUOp == 4'd7) begin
          hi_d = E_O1;
        end else if (E_MDUOp == 4'd8) begin
          lo_d = E_O1;
        end
      end
      S_MULT, S_DIV: begin
        if (cnt == 4'd1) begin
          hi_d    = thi;
          lo_d    = tlo;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      thi   <= 32'd0;
      tlo   <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      thi   <= thi_d;
      tlo   <= tlo_d;
      HI    <= hi_d;
      LO    <= lo_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed testbench for e_mdu (default parameters: mult 5 cycles, div 10).
// Works in both builds; the div section follows MDU_DIV_EN.

module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] o1, o2;
  logic [3:0]  mdu_op;
  logic        start, busy;
  logic [31:0] mdu_o, hi, lo;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_hi, exp_lo;

  e_mdu dut (
    .clk         (clk),
    .reset       (reset),
    .E_O1        (o1),
    .E_O2        (o2),
    .E_MDUOp     (mdu_op),
    .E_MDU_Start (start),
    .E_MDU_Busy  (busy),
    .E_MDU_O     (mdu_o),
    .HI          (hi),
    .LO          (lo),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a mult/div op, expect Start, let it be accepted, return to bubble.
  task automatic start_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    mdu_op = op;
    o1 = a;
    o2 = b;
    #1;
    chk({tag, "_start"}, start, 1'b1);
    step();
    mdu_op = 4'd0;
  endtask

  // Count remaining busy cycles, bounded.
  task automatic wait_busy(input string tag, input int exp_n);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, n, exp_n);
  endtask

  task automatic chk_hilo(input string tag);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset  = 1'b1;
    mdu_op = 4'd0;
    o1     = 32'd0;
    o2     = 32'd0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_o", mdu_o, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk_hilo("rst");
    step();
    step();
    reset = 1'b0;
    step();

    // mult -2 * 3
    start_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_held", hi, 32'd0);
    wait_busy("mult", 5);
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFFA;
    chk_hilo("mult");

    // multu, back-to-back
    start_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_busy("multu", 5);
    exp_hi = 32'h0000_0002;
    exp_lo = 32'hFFFF_FFFA;
    chk_hilo("multu");

`ifdef MDU_DIV_EN
    start_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div", 10);
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFFD;
    chk_hilo("div");

    start_op("divu0", 4'd4, 32'd7, 32'd0);
    wait_busy("divu0", 10);
    chk_hilo("divu0");

    start_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("divovf", 10);
    exp_hi = 32'd0;
    exp_lo = 32'h8000_0000;
    chk_hilo("divovf");

    start_op("divu", 4'd4, 32'd100, 32'd7);
    wait_busy("divu", 10);
    exp_hi = 32'd2;
    exp_lo = 32'd14;
    chk_hilo("divu");
`else
    mdu_op = 4'd3;
    o1 = 32'd8;
    o2 = 32'd2;
    #1;
    chk("nodiv_start", start, 1'b0);
    step();
    chk("nodiv_busy", busy, 1'b0);
    mdu_op = 4'd4;
    #1;
    chk("nodivu_start", start, 1'b0);
    step();
    mdu_op = 4'd0;
    chk("nodivu_busy", busy, 1'b0);
    chk_hilo("nodiv");
`endif

    // mthi then mfhi / mflo / bubbles
    mdu_op = 4'd7;
    o1 = 32'h1234_5678;
    step();
    exp_hi = 32'h1234_5678;
    mdu_op = 4'd5;
    #1;
    chk_hilo("mthi");
    chk("mfhi_o", mdu_o, 32'h1234_5678);
    mdu_op = 4'd6;
    #1;
    chk("mflo_o", mdu_o, exp_lo);
    mdu_op = 4'd9;
    #1;
    chk("op9_o", mdu_o, 32'd0);
    chk("op9_start", start, 1'b0);
    step();
    chk_hilo("op9");

    // ops while busy are dropped
    mdu_op = 4'd0;
    start_op("mult34", 4'd1, 32'd3, 32'd4);
    mdu_op = 4'd8;
    o1 = 32'hDEAD_BEEF;
    step();
    chk("mtlo_busy_lo", lo, exp_lo);
    mdu_op = 4'd7;
    step();
    chk("mthi_busy_hi", hi, exp_hi);
    mdu_op = 4'd2;
    o1 = 32'd5;
    o2 = 32'd5;
    #1;
    chk("busy_start", start, 1'b0);
    step();
    mdu_op = 4'd0;
    wait_busy("mult34", 2);
    exp_hi = 32'd0;
    exp_lo = 32'd12;
    chk_hilo("mult34");

    // async reset mid-operation
`ifdef MDU_DIV_EN
    start_op("rstdiv", 4'd3, 32'd100, 32'd7);
`else
    start_op("rstdiv", 4'd1, 32'd100, 32'd7);
`endif
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    chk_hilo("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (12) step();
    chk("post_rst_busy", busy, 1'b0);
    chk_hilo("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It consumes the operand pair and decoded MDU operation latched by the D→E pipeline register, runs multi-cycle mult/div operations, and holds the architectural HI/LO registers. It exports busy/start status to the hazard unit, which stalls D-stage MDU instructions, and exports a read value for mfhi/mflo to the E-stage result mux.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu, in cycles (≥1)
- DIV_CYCLES, 10, busy duration of div/divu, in cycles (≥1)
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- E_O1  in  32  rs operand from the D→E register
- E_O2  in  32  rt operand from the D→E register
- E_MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 treated as none
- E_MDU_Start  out  1  combinational: E_MDUOp is mult/multu/div/divu and E_MDU_Busy is 0
- E_MDU_Busy  out  1  registered: an operation is in flight
- E_MDU_O  out  32  combinational: HI for mfhi, LO for mflo, else 0
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

## Operation
- State: IDLE, MULT, DIV; down-counter cnt (4 bits, wide enough for both parameters); temporary result pair tHI/tLO.
- IDLE, Start with mult/multu: compute 64-bit product (signed for mult, unsigned for multu) into {tHI,tLO}; cnt←MULT_CYCLES; → MULT.
- IDLE, Start with div/divu: tLO←quotient, tHI←remainder; signed div truncates toward zero, remainder takes sign of dividend; cnt←DIV_CYCLES; → DIV.
- MULT/DIV: cnt decrements each cycle; when cnt reaches 1, on that edge HI←tHI, LO←tLO, cnt←0, → IDLE.
- Divide by zero (E_O2=0): runs full DIV_CYCLES; HI/LO left unchanged at completion.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: HI or LO ←E_O1 at the next edge; other register unchanged.
- Any op (start, mthi, mtlo) presented while Busy: ignored; no state change. The hazard unit must prevent this; the block does not rely on it.
- mfhi/mflo: E_MDU_O reflects the current HI/LO register value with no forwarding of in-flight results.
- Bubbles from the D→E register arrive as E_MDUOp=0 and have no effect.

## Timing
- Reset (async): HI=0, LO=0, tHI=0, tLO=0, cnt=0, state IDLE, E_MDU_Busy=0; E_MDU_Start and E_MDU_O follow their inputs combinationally (0 when E_MDUOp=0). Reset mid-operation aborts it; HI/LO do not receive the result.
- Start sampled at edge t0; E_MDU_Busy=1 from t0 until edge t0+N (N=MULT_CYCLES or DIV_CYCLES); HI/LO update and Busy falls at the same edge t0+N.
- E_MDU_Busy is high for exactly N cycles per operation; a new Start is accepted in the cycle after Busy falls.
- mthi/mtlo: single cycle; result visible on HI/LO after the next edge.
- Hazard contract: a D-stage MDU instruction stalls while (E_MDU_Start | E_MDU_Busy).

## Configuration
- MDU_DIV_EN: when defined, div/divu are implemented as described. When undefined, E_MDUOp 3 and 4 are treated as none: no Start, no Busy, and HI/LO unchanged; the DIV state and divider logic are not synthesised.

## Test plan
- Reset, then mult with E_O1=0xFFFFFFFE and E_O2=3 → Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- div with E_O1=0xFFFFFFF9 (−7) and E_O2=2 → Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with 7 and 0 → HI/LO unchanged.
- mthi with 0x12345678, then mfhi → HI=0x12345678 and E_MDU_O=0x12345678. An mtlo held during Busy → LO unchanged.
- Assert reset asynchronously at cycle 3 of a div → Busy=0 and HI=LO=0 immediately, with no later update.
- Build without MDU_DIV_EN, then apply div with 8 and 2 → E_MDU_Start=0, Busy stays 0, HI/LO unchanged.
